// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the matrix-keypad scanner.
//   state_e    - scanner FSM states
//   key_w()    - width of a raw key index for a given matrix size
//   phone_code - maps a raw 4x3 phone-layout index to its symbol code
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan    = 2'd0,
        StPressDb = 2'd1,
        StHeld    = 2'd2,
        StRelDb   = 2'd3
    } state_e;

    // Raw key index width: clog2(rows * cols).
    function automatic int unsigned key_w(input int unsigned rows, input int unsigned cols);
        return $clog2(rows * cols);
    endfunction

    // 4x3 phone layout: rows 1-2-3 / 4-5-6 / 7-8-9 / *-0-#.
    localparam int unsigned PhoneRows = 4;
    localparam int unsigned PhoneCols = 3;

    typedef logic [3:0] code_t;

    localparam code_t CodeStar = 4'd10;
    localparam code_t CodeHash = 4'd11;
    localparam code_t CodeNone = 4'd13;

    function automatic code_t phone_code(input logic [3:0] idx);
        code_t code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd4;
            4'd4:    code = 4'd5;
            4'd5:    code = 4'd6;
            4'd6:    code = 4'd7;
            4'd7:    code = 4'd8;
            4'd8:    code = 4'd9;
            4'd9:    code = CodeStar;
            4'd10:   code = 4'd0;
            4'd11:   code = CodeHash;
            default: code = CodeNone;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo: small synchronous FIFO for key events.
//   clock, reset - system clock, synchronous active-high reset (empties FIFO)
//   push/push_data - write request; ignored when full unless a pop happens the same cycle
//   pop          - read request; ignored when empty
//   head_data    - oldest entry (held stable until popped)
//   empty, full  - occupancy flags
module key_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CountFull);
    assign do_pop    = pop && !empty;
    // A pop frees the slot being overwritten, so a full FIFO still accepts.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix-keypad scanner with debounce, auto-repeat and event FIFO.
//   clock, reset  - system clock, synchronous active-high reset
//   cols_n        - asynchronous active-low column inputs (pulled up)
//   rows_n        - active-low row drives, at most one low
//   repeat_en     - enables auto-repeat while a key is held
//   key_code      - raw index (row*NUM_COLS+col) at the FIFO head
//   key_valid     - FIFO non-empty; key_ready pops when both high
//   key_held      - a debounced key is down
//   overflow      - sticky, an event was dropped; overflow_clr clears it
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_ROWS       = 4,
    parameter int unsigned NUM_COLS       = 3,
    parameter int unsigned CLK_DIV        = 500000,
    parameter int unsigned SETTLE_TICKS   = 2,
    parameter int unsigned DEBOUNCE_TICKS = 3,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_RATE    = 10,
    parameter int unsigned FIFO_DEPTH     = 4,
    localparam int unsigned KEY_W         = key_w(NUM_ROWS, NUM_COLS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] cols_n,
    output logic [NUM_ROWS-1:0] rows_n,
    input  logic                repeat_en,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_held,
    output logic                overflow,
    input  logic                overflow_clr
);

    typedef logic [KEY_W-1:0] idx_t;

    localparam int unsigned PW     = $clog2(CLK_DIV + 1);
    localparam int unsigned SW     = $clog2(SETTLE_TICKS + 1);
    localparam int unsigned DW     = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW     = $clog2(RepMax + 1);

    localparam logic [PW-1:0] PrescLast  = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE_TICKS - 1);
    localparam logic [DW-1:0] DbLast     = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [RW-1:0] DelayLast  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RateLast   = RW'(REPEAT_RATE - 1);
    localparam idx_t          RowLast    = idx_t'(NUM_ROWS - 1);
    localparam idx_t          ColsK      = idx_t'(NUM_COLS);

    state_e              state_q, state_d;
    idx_t                row_q, row_d;
    idx_t                col_q, col_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [DW-1:0]       db_q, db_d;
    logic [RW-1:0]       rep_q, rep_d;
    logic                rep_fired_q, rep_fired_d;
    logic                held_q, held_d;
    logic [NUM_ROWS-1:0] rows_n_q, rows_n_d;
    logic                ovf_q, ovf_d;
    logic [NUM_COLS-1:0] cols_meta_q, cols_meta_d;
    logic [NUM_COLS-1:0] cols_sync_q, cols_sync_d;

    logic tick;
    logic any_low;
    idx_t low_col;
    logic col_low;
    idx_t next_row;
    logic press_ok, release_ok;
    logic push, pop;
    idx_t push_code;
    logic fifo_empty, fifo_full;

    assign tick     = (presc_q == PrescLast);
    assign next_row = (row_q == RowLast) ? '0 : row_q + 1'b1;

    // Column decode on the synchronised inputs; lowest low column wins.
    always_comb begin
        any_low = 1'b0;
        low_col = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (!cols_sync_q[c]) begin
                any_low = 1'b1;
                low_col = idx_t'(c);
            end
        end
        col_low = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_q == idx_t'(c)) begin
                col_low = !cols_sync_q[c];
            end
        end
    end

    always_comb begin
        cols_meta_d = cols_n;
        cols_sync_d = cols_meta_q;
        presc_d     = tick ? '0 : presc_q + 1'b1;
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        settle_d    = settle_q;
        db_d        = db_q;
        rep_d       = rep_q;
        rep_fired_d = rep_fired_q;
        held_d      = held_q;
        press_ok    = 1'b0;
        release_ok  = 1'b0;
        push        = 1'b0;

        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (settle_q != SettleLast) begin
                        settle_d = settle_q + 1'b1;
                    end else begin
                        settle_d = '0;
                        if (any_low) begin
                            col_d = low_col;
                            db_d  = DW'(1);
                            if (DEBOUNCE_TICKS == 1) begin
                                press_ok = 1'b1;
                            end else begin
                                state_d = StPressDb;
                            end
                        end else begin
                            row_d = next_row;
                        end
                    end
                end
                StPressDb: begin
                    if (col_low) begin
                        if (db_q == DbLast) begin
                            press_ok = 1'b1;
                        end else begin
                            db_d = db_q + 1'b1;
                        end
                    end else begin
                        // Bounce: rescan the same row from a fresh settle.
                        state_d  = StScan;
                        settle_d = '0;
                    end
                end
                StHeld: begin
                    if (!col_low) begin
                        db_d = DW'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            release_ok = 1'b1;
                        end else begin
                            state_d = StRelDb;
                        end
                    end else if (repeat_en) begin
                        // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE.
                        if (rep_q == (rep_fired_q ? RateLast : DelayLast)) begin
                            push        = 1'b1;
                            rep_d       = '0;
                            rep_fired_d = 1'b1;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end else begin
                        rep_d       = '0;
                        rep_fired_d = 1'b0;
                    end
                end
                StRelDb: begin
                    if (!col_low) begin
                        if (db_q == DbLast) begin
                            release_ok = 1'b1;
                        end else begin
                            db_d = db_q + 1'b1;
                        end
                    end else begin
                        // Repeat progress is kept across a release glitch.
                        state_d = StHeld;
                    end
                end
                default: state_d = StScan;
            endcase

            if (press_ok) begin
                push        = 1'b1;
                held_d      = 1'b1;
                state_d     = StHeld;
                rep_d       = '0;
                rep_fired_d = 1'b0;
            end
            if (release_ok) begin
                held_d   = 1'b0;
                row_d    = next_row;
                settle_d = '0;
                state_d  = StScan;
            end
        end

        for (int r = 0; r < NUM_ROWS; r++) begin
            rows_n_d[r] = (row_d != idx_t'(r));
        end
    end

    assign push_code = row_q * ColsK + col_d;
    assign pop       = key_valid && key_ready;

    // Set wins over clear.
    assign ovf_d = (push && fifo_full && !pop) ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StScan;
            row_q       <= '0;
            col_q       <= '0;
            presc_q     <= '0;
            settle_q    <= '0;
            db_q        <= '0;
            rep_q       <= '0;
            rep_fired_q <= 1'b0;
            held_q      <= 1'b0;
            rows_n_q    <= '1;
            ovf_q       <= 1'b0;
            cols_meta_q <= '1;
            cols_sync_q <= '1;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            presc_q     <= presc_d;
            settle_q    <= settle_d;
            db_q        <= db_d;
            rep_q       <= rep_d;
            rep_fired_q <= rep_fired_d;
            held_q      <= held_d;
            rows_n_q    <= rows_n_d;
            ovf_q       <= ovf_d;
            cols_meta_q <= cols_meta_d;
            cols_sync_q <= cols_sync_d;
        end
    end

    key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .head_data (key_code),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign key_valid = !fifo_empty;
    assign rows_n    = rows_n_q;
    assign key_held  = held_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner.
// One tick = 4 clocks; the stimulus stays aligned to tick edges counted from reset release.
module tb_keypad_scanner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] cols_n;
    logic [3:0] rows_n;
    logic       repeat_en = 1'b0;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       key_held;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    logic       pressed = 1'b0;
    int         prow = 0;
    int         pcol = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [3:0] got [$];
    int         base;

    always #5 clock = ~clock;

    // Keypad model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        cols_n = 3'b111;
        if (pressed && !rows_n[prow]) cols_n[pcol] = 1'b0;
    end

    // Record every accepted pop (sampled mid-cycle, before the popping edge).
    always @(negedge clock) begin
        if (!reset && key_valid && key_ready) got.push_back(key_code);
    end

    keypad_scanner #(
        .NUM_ROWS       (4),
        .NUM_COLS       (3),
        .CLK_DIV        (4),
        .SETTLE_TICKS   (2),
        .DEBOUNCE_TICKS (3),
        .REPEAT_DELAY   (6),
        .REPEAT_RATE    (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cols_n       (cols_n),
        .rows_n       (rows_n),
        .repeat_en    (repeat_en),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_held     (key_held),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_step(input int n);
        repeat (4 * n) @(posedge clock);
        #1;
    endtask

    task automatic press_until_held(input int r, input int c, input string tag);
        logic ok;
        ok = 1'b0;
        prow = r;
        pcol = c;
        pressed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick_step(1);
            if (key_held) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    task automatic release_until_free(input string tag);
        logic ok;
        ok = 1'b0;
        pressed = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_step(1);
            if (!key_held) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    initial begin
        logic [3:0] exp_rows [4];
        logic [3:0] exp_codes [4];

        // Reset state (T0).
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_rows", rows_n, 4'b1111);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);
        check("rst_ovf", overflow, 0);

        // 1: idle scan, 2 ticks (8 clocks) per row.
        exp_rows[0] = 4'b1101;
        exp_rows[1] = 4'b1011;
        exp_rows[2] = 4'b0111;
        exp_rows[3] = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            tick_step(1);
            check("scan_mid", rows_n, (i == 0) ? 4'b1110 : exp_rows[i-1]);
            tick_step(1);
            check("scan_next", rows_n, exp_rows[i]);
            check("scan_valid", key_valid, 0);
        end

        // 2: row1/col2 held 40 ticks, no repeat (now T8).
        prow = 1;
        pcol = 2;
        pressed = 1'b1;
        tick_step(6);                                   // T14: accepted
        check("t2_held", key_held, 1);
        check("t2_valid", key_valid, 1);
        check("t2_code", key_code, 5);
        tick_step(40);                                  // T54
        check("t2_held_long", key_held, 1);
        check("t2_frozen_row", rows_n, 4'b1101);
        pressed = 1'b0;
        tick_step(2);                                   // T56
        check("t2_rel_db", key_held, 1);
        tick_step(1);                                   // T57
        check("t2_released", key_held, 0);
        check("t2_next_row", rows_n, 4'b1011);
        check("t2_count", got.size(), 1);
        if (got.size() > 0) check("t2_event", got[0], 5);

        // 3: bounce on row3/col0, two low samples only.
        tick_step(3);                                   // T60
        prow = 3;
        pcol = 0;
        pressed = 1'b1;
        tick_step(2);                                   // T62
        check("t3_no_held", key_held, 0);
        pressed = 1'b0;
        tick_step(1);                                   // T63
        check("t3_same_row", rows_n, 4'b0111);
        tick_step(1);
        check("t3_settle", rows_n, 4'b0111);
        tick_step(1);                                   // T65
        check("t3_advance", rows_n, 4'b1110);
        check("t3_no_event", got.size(), 1);

        // 4: key 0 held with auto-repeat.
        prow = 0;
        pcol = 0;
        pressed = 1'b1;
        repeat_en = 1'b1;
        tick_step(4);                                   // T69: accepted
        check("t4_accept_valid", key_valid, 1);
        check("t4_accept_code", key_code, 0);
        tick_step(5);                                   // T74
        check("t4_no_early_rep", key_valid, 0);
        tick_step(1);                                   // T75: first repeat
        check("t4_rep1_valid", key_valid, 1);
        check("t4_rep1_code", key_code, 0);
        for (int i = 0; i < 4; i++) begin
            tick_step(1);
            check("t4_gap", key_valid, 0);
            tick_step(1);
            check("t4_rep_valid", key_valid, 1);
        end                                             // T83
        pressed = 1'b0;
        tick_step(3);                                   // T86
        check("t4_released", key_held, 0);
        check("t4_row", rows_n, 4'b1101);
        check("t4_count", got.size(), 7);
        for (int i = 1; i < got.size(); i++) check("t4_event", got[i], 0);
        repeat_en = 1'b0;

        // 5: consumer stalled, five presses into a depth-4 FIFO.
        key_ready = 1'b0;
        press_until_held(1, 0, "t5_p0");
        release_until_free("t5_r0");
        press_until_held(2, 1, "t5_p1");
        release_until_free("t5_r1");
        press_until_held(3, 2, "t5_p2");
        release_until_free("t5_r2");
        press_until_held(0, 1, "t5_p3");
        release_until_free("t5_r3");
        check("t5_no_ovf", overflow, 0);
        check("t5_head", key_code, 3);
        press_until_held(2, 0, "t5_p4");
        check("t5_ovf", overflow, 1);
        release_until_free("t5_r4");
        check("t5_ovf_sticky", overflow, 1);
        check("t5_head_stable", key_code, 3);
        overflow_clr = 1'b1;
        @(posedge clock);
        #1 overflow_clr = 1'b0;
        check("t5_ovf_clr", overflow, 0);
        base = got.size();
        key_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("t5_drained", key_valid, 0);
        check("t5_pop_count", got.size(), base + 4);
        exp_codes[0] = 4'd3;
        exp_codes[1] = 4'd7;
        exp_codes[2] = 4'd11;
        exp_codes[3] = 4'd1;
        for (int i = 0; i < 4; i++) begin
            if (base + i < got.size()) check("t5_order", got[base+i], exp_codes[i]);
        end

        // 6: reset while a key is held and an event is pending.
        key_ready = 1'b0;
        press_until_held(1, 1, "t6_p");
        check("t6_pending", key_valid, 1);
        check("t6_code", key_code, 4);
        reset = 1'b1;
        pressed = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        check("t6_rows", rows_n, 4'b1111);
        check("t6_held", key_held, 0);
        check("t6_valid", key_valid, 0);
        key_ready = 1'b1;
        tick_step(1);
        check("t6_row0", rows_n, 4'b1110);
        tick_step(1);
        check("t6_row1", rows_n, 4'b1101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
